// File: rtl/uart_rx_deframer.sv
// Purpose: 16x-oversampled UART receive deframer (8 data bits, optional parity, 1 or 2 stop bits).
// Latency: urxd_i passes a 2-flop synchronizer; rx_valid_o rises 1 cycle after DONE (tick 15 of the last stop bit).
// Backpressure: one holding register; a frame that completes while it is full is dropped and overrun_o pulses.
// Optional feature: define UART_RX_BREAK_DET_EN to enable break detection on break_o.
module uart_rx_deframer #(
    parameter int DIV_W = 16,
    parameter int OSR   = 16
) (
    input  logic             clk26m,
    input  logic             rst26m,
    input  logic             rx_en_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             parity_en_i,
    input  logic             parity_odd_i,
    input  logic             stop2_i,
    input  logic             urxd_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             parity_err_o,
    output logic             frame_err_o,
    output logic             overrun_o,
    output logic             break_o
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;

    localparam logic [3:0] LAST_TICK = 4'(OSR - 1);
    localparam logic [3:0] TICK_S0   = 4'd7;
    localparam logic [3:0] TICK_S1   = 4'd8;
    localparam logic [3:0] TICK_S2   = 4'd9;

    state_t           state, state_n;
    logic             sync1, sync2, line_prev;
    logic [DIV_W-1:0] div_cnt, div_reload;
    logic             tick;
    logic [3:0]       tcnt;
    logic             samp0, samp1, maj;
    logic             commit, bit_end, fall, start;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             cfg_par_en, cfg_par_odd, cfg_stop2;
    logic             par_err, frm_err;
    logic             done, load;
    logic             brk_block;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    // Edge detection needs a high level before a low one, so after a frame error
    // a line still stuck low cannot start a new frame until it has gone high.
    always_ff @(posedge clk26m) begin
        if (rst26m) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= urxd_i;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign fall       = line_prev & ~sync2;
    assign div_reload = (baud_div_i == '0) ? '0 : baud_div_i - DIV_W'(1);
    assign tick       = rx_en_i && (div_cnt == '0);

    // Oversample tick down-counter; divisor changes are picked up at reload.
    always_ff @(posedge clk26m) begin
        if (rst26m)
            div_cnt <= '0;
        else if (!rx_en_i || div_cnt == '0)
            div_cnt <= div_reload;
        else
            div_cnt <= div_cnt - DIV_W'(1);
    end

    assign start   = (state == IDLE) && rx_en_i && fall && !brk_block;
    assign commit  = tick && (tcnt == TICK_S2);
    assign bit_end = tick && (tcnt == LAST_TICK);
    assign maj     = (samp0 & samp1) | (samp0 & sync2) | (samp1 & sync2);

    // Tick-within-bit counter, phase-aligned to the start edge.
    always_ff @(posedge clk26m) begin
        if (rst26m)
            tcnt <= '0;
        else if (start)
            tcnt <= '0;
        else if (tick)
            tcnt <= tcnt + 4'd1;
    end

    // FSM state register.
    always_ff @(posedge clk26m) begin
        if (rst26m)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic; dropping rx_en_i abandons any partial frame.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = START;
            START:   if (commit && maj) state_n = IDLE;
                     else if (bit_end) state_n = DATA;
            DATA:    if (bit_end && bit_idx == 3'd7) state_n = cfg_par_en ? PARITY : STOP1;
            PARITY:  if (bit_end) state_n = STOP1;
            STOP1:   if (bit_end) state_n = cfg_stop2 ? STOP2 : DONE;
            STOP2:   if (bit_end) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (!rx_en_i && state != IDLE && state != DONE)
            state_n = IDLE;
    end

    // Frame datapath: mid-bit samples, shift register, per-frame config and error flags.
    always_ff @(posedge clk26m) begin
        if (rst26m) begin
            samp0       <= 1'b1;
            samp1       <= 1'b1;
            bit_idx     <= '0;
            shift       <= '0;
            cfg_par_en  <= 1'b0;
            cfg_par_odd <= 1'b0;
            cfg_stop2   <= 1'b0;
            par_err     <= 1'b0;
            frm_err     <= 1'b0;
        end else begin
            if (tick && tcnt == TICK_S0) samp0 <= sync2;
            if (tick && tcnt == TICK_S1) samp1 <= sync2;
            if (state == START && bit_end) begin
                cfg_par_en  <= parity_en_i;
                cfg_par_odd <= parity_odd_i;
                cfg_stop2   <= stop2_i;
                bit_idx     <= '0;
                par_err     <= 1'b0;
                frm_err     <= 1'b0;
            end
            if (state == DATA && commit)  shift   <= {maj, shift[7:1]};
            if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;
            if (state == PARITY && commit) par_err <= (maj != (^shift ^ cfg_par_odd));
            if ((state == STOP1 || state == STOP2) && commit && !maj) frm_err <= 1'b1;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic       par_bit, stop1_bit, brk_wait, brk_det;
    logic [3:0] hi_cnt;

    assign brk_det   = (shift == 8'h00) && !par_bit && !stop1_bit;
    assign brk_block = brk_wait;
    assign break_o   = done && brk_det;

    // Break tracking: raw parity/stop1 bits, then hold off new starts until 16 high ticks.
    always_ff @(posedge clk26m) begin
        if (rst26m) begin
            par_bit   <= 1'b0;
            stop1_bit <= 1'b1;
            brk_wait  <= 1'b0;
            hi_cnt    <= '0;
        end else begin
            if (state == START && bit_end) par_bit   <= 1'b0;
            if (state == PARITY && commit) par_bit   <= maj;
            if (state == STOP1 && commit)  stop1_bit <= maj;
            if (done && brk_det) begin
                brk_wait <= 1'b1;
                hi_cnt   <= '0;
            end else if (brk_wait && tick) begin
                if (!sync2) begin
                    hi_cnt <= '0;
                end else if (hi_cnt == LAST_TICK) begin
                    brk_wait <= 1'b0;
                    hi_cnt   <= '0;
                end else begin
                    hi_cnt <= hi_cnt + 4'd1;
                end
            end
        end
    end
`else
    assign brk_block = 1'b0;
    assign break_o   = 1'b0;
`endif

    assign done      = (state == DONE);
    assign load      = done && (!rx_valid_o || rx_ready_i);
    assign overrun_o = done && !load;

    // Holding register: load on DONE when free or being drained, clear on handshake.
    always_ff @(posedge clk26m) begin
        if (rst26m) begin
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else if (load) begin
            rx_data_o    <= shift;
            rx_valid_o   <= 1'b1;
            parity_err_o <= par_err;
            frame_err_o  <= frm_err;
        end else if (rx_valid_o && rx_ready_i) begin
            rx_valid_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: frames are built bit by bit on urxd_i,
// a frame-level model predicts data/parity/framing/overrun/break, one process compares.
`timescale 1ns/1ps
module tb_uart_rx_deframer;

    localparam int DIV = 14;
    localparam int BIT = 16 * DIV;

`ifdef UART_RX_BREAK_DET_EN
    localparam bit BRK_ON = 1'b1;
`else
    localparam bit BRK_ON = 1'b0;
`endif

    logic        clk26m = 1'b0;
    logic        rst26m = 1'b1;
    logic        rx_en_i = 1'b0;
    logic [15:0] baud_div_i = 16'd0;
    logic        parity_en_i = 1'b0;
    logic        parity_odd_i = 1'b0;
    logic        stop2_i = 1'b0;
    logic        urxd_i = 1'b1;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b1;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        overrun_o;
    logic        break_o;

    uart_rx_deframer #(.DIV_W(16), .OSR(16)) dut (
        .clk26m       (clk26m),
        .rst26m       (rst26m),
        .rx_en_i      (rx_en_i),
        .baud_div_i   (baud_div_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .stop2_i      (stop2_i),
        .urxd_i       (urxd_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .break_o      (break_o)
    );

    always #19 clk26m = ~clk26m;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         exp_ovr = 0;
    int         exp_brk = 0;
    int         ovr_seen = 0;
    int         brk_seen = 0;
    int         vcyc = 0;
    int         v0, o0, b0;
    logic [7:0] acc_data = 8'h00;
    logic       acc_pe = 1'b0;
    logic       acc_fe = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk26m);
        #1;
    endtask

    // Frame-level model: what the receiver must report for the bits put on the wire.
    task automatic expect_frame(input logic [7:0] d, input logic pbit, input logic s1, input logic s2);
        exp_t e;
        logic brk;
        e.data = d;
        e.pe   = parity_en_i && (pbit != (^d ^ parity_odd_i));
        e.fe   = !s1 || (stop2_i && !s2);
        brk    = (d == 8'h00) && (!parity_en_i || !pbit) && !s1;
        if (brk && BRK_ON) exp_brk++;
        if (exp_q.size() != 0 && !rx_ready_i) exp_ovr++;
        else exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic b);
        urxd_i = b;
        cyc(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1, input logic s2);
        drive_bit(1'b1);
        expect_frame(d, pbit, s1, s2);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (parity_en_i) drive_bit(pbit);
        drive_bit(s1);
        if (stop2_i) drive_bit(s2);
        urxd_i = 1'b1;
    endtask

    task automatic settle(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * BIT) begin
            cyc(1);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Compare process: every cycle a byte is presented it must match the model head.
    initial begin
        forever begin
            @(negedge clk26m);
            if (!rst26m) begin
                if (rx_valid_o) begin
                    vcyc++;
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", 32'(rx_valid_o), 32'd0);
                    end else begin
                        chk("rx_stream", 32'({rx_data_o, parity_err_o, frame_err_o}), 32'(exp_q[0]));
                        if (rx_ready_i) begin
                            acc_data = rx_data_o;
                            acc_pe   = parity_err_o;
                            acc_fe   = frame_err_o;
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (overrun_o) ovr_seen++;
                if (break_o) brk_seen++;
            end
        end
    end

    initial begin
        baud_div_i = 16'(DIV);
        rx_en_i    = 1'b1;
        rst26m     = 1'b1;
        cyc(4);
        chk("reset_outputs", 32'({rx_data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_o, break_o}), 32'd0);
        rst26m = 1'b0;
        cyc(2 * BIT);

        // 8N1 0xA5 with ready held high
        v0 = vcyc;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        settle("a5_drain");
        chk("a5_data", 32'(acc_data), 32'h A5);
        chk("a5_flags", 32'({acc_pe, acc_fe}), 32'd0);
        chk("a5_valid_cycles", 32'(vcyc - v0), 32'd1);

        // Even then odd parity, 0x3C with parity bit 1
        parity_en_i  = 1'b1;
        parity_odd_i = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        settle("p_even_drain");
        chk("p_even_data", 32'(acc_data), 32'h3C);
        chk("p_even_pe", 32'(acc_pe), 32'd1);
        parity_odd_i = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        settle("p_odd_drain");
        chk("p_odd_pe", 32'(acc_pe), 32'd0);

        // Two stop bits, second one low, then a clean frame
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b0;
        stop2_i      = 1'b1;
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        settle("s2_drain");
        chk("s2_data", 32'(acc_data), 32'h55);
        chk("s2_fe", 32'(acc_fe), 32'd1);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1);
        settle("s2_clean_drain");
        chk("s2_clean", 32'({acc_data, acc_pe, acc_fe}), 32'({8'h0F, 2'b00}));
        stop2_i = 1'b0;

        // Overrun: hold 0x11, 0x22 must be dropped
        rx_ready_i = 1'b0;
        o0 = ovr_seen;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        cyc(BIT / 2);
        chk("ovr_pulses", 32'(ovr_seen - o0), 32'd1);
        chk("ovr_model", 32'(ovr_seen), 32'(exp_ovr));
        chk("ovr_hold_data", 32'(rx_data_o), 32'h11);
        chk("ovr_hold_valid", 32'(rx_valid_o), 32'd1);
        rx_ready_i = 1'b1;
        @(negedge clk26m);
        @(negedge clk26m);
        chk("ovr_valid_drop", 32'(rx_valid_o), 32'd0);
        chk("ovr_accepted", 32'(acc_data), 32'h11);
        cyc(1);

        // 100-cycle low glitch on idle line
        v0 = vcyc;
        urxd_i = 1'b0;
        cyc(100);
        urxd_i = 1'b1;
        cyc(2 * BIT);
        chk("glitch_valid", 32'(rx_valid_o), 32'd0);
        chk("glitch_no_byte", 32'(vcyc - v0), 32'd0);

        // Reset during DATA with a byte pending
        rx_ready_i = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        cyc(BIT / 2);
        chk("pre_reset_hold", 32'({rx_valid_o, rx_data_o}), 32'({1'b1, 8'h5A}));
        drive_bit(1'b0);
        drive_bit(1'b1);
        urxd_i = 1'b0;
        cyc(BIT / 2);
        rst26m = 1'b1;
        exp_q.delete();
        cyc(1);
        rst26m = 1'b0;
        urxd_i = 1'b1;
        chk("rst_valid", 32'(rx_valid_o), 32'd0);
        chk("rst_data", 32'(rx_data_o), 32'd0);
        chk("rst_flags", 32'({parity_err_o, frame_err_o, overrun_o, break_o}), 32'd0);
        rx_ready_i = 1'b1;
        cyc(2 * BIT);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        settle("post_rst_drain");
        chk("post_rst_data", 32'({acc_data, acc_pe, acc_fe}), 32'({8'h81, 2'b00}));

        // Line held low for 12 bit times
        b0 = brk_seen;
        cyc(BIT);
        expect_frame(8'h00, 1'b0, 1'b0, 1'b0);
        urxd_i = 1'b0;
        cyc(12 * BIT);
        urxd_i = 1'b1;
        settle("brk_drain");
        chk("brk_data", 32'(acc_data), 32'd0);
        chk("brk_fe", 32'({acc_pe, acc_fe}), 32'd1);
        chk("brk_pulses", 32'(brk_seen - b0), 32'(BRK_ON));
        chk("brk_model", 32'(brk_seen), 32'(exp_brk));
        cyc(2 * BIT);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
        settle("post_brk_drain");
        chk("post_brk_data", 32'({acc_data, acc_pe, acc_fe}), 32'({8'hC3, 2'b00}));
        chk("final_ovr_model", 32'(ovr_seen), 32'(exp_ovr));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side serial deframer in the 26 MHz UART domain. It sits directly downstream of the urxd pin, upstream of the RX FIFO / APB register bank.
- Oversamples the serial line 16x off a programmable baud divider and recovers 8-bit frames with optional parity and 1 or 2 stop bits.
- Presents each byte with error sideband on a valid/ready handshake.

Parameters:
- DIV_W, 16, width of the baud divisor input.
- OSR, 16, oversample ticks per bit; fixed legal value 16.

Ports:
- clk26m  in  1  UART-domain clock, 26 MHz
- rst26m  in  1  synchronous, active-high reset
- rx_en_i  in  1  receiver enable
- baud_div_i  in  DIV_W  clk26m cycles per oversample tick; 0 is treated as 1
- parity_en_i  in  1  parity bit present
- parity_odd_i  in  1  1 = odd parity, 0 = even parity
- stop2_i  in  1  1 = two stop bits
- urxd_i  in  1  asynchronous serial input, idle high
- rx_data_o  out  8  received byte, LSB first on the wire
- rx_valid_o  out  1  byte plus flags available
- rx_ready_i  in  1  consumer accepts the byte
- parity_err_o  out  1  parity mismatch for the held byte; valid with rx_valid_o
- frame_err_o  out  1  a stop bit sampled 0 for the held byte; valid with rx_valid_o
- overrun_o  out  1  one-cycle pulse: a frame completed while the holding register was full
- break_o  out  1  break-detect pulse; see Optional Feature

Behaviour:
- Reset values: rx_data_o=0, rx_valid_o=0, parity_err_o=0, frame_err_o=0, overrun_o=0, break_o=0. Synchronizer flops reset to 1. FSM resets to IDLE. Counters reset to 0.
- Synchronizer: urxd_i passes through 2 flops before any use; this adds 2 cycles of latency.
- Tick generator:
  - Down-counter reloads with max(baud_div_i,1)-1 and emits tick when it reaches 0.
  - It runs only when rx_en_i=1; otherwise it is held at the reload value.
  - A baud_div_i change takes effect at the next reload.
- Bit timing:
  - A 4-bit tick counter (0..15) is reset to 0 on start-edge detection.
  - The bit sample is the majority of the synced line at tick counts 7, 8 and 9.
  - The sample is committed at tick count 9; the bit ends at tick count 15.
- FSM states and transitions:
  - IDLE: a synced falling edge with rx_en_i=1 goes to START.
  - START: a majority sample of 1 is a false start; return to IDLE with no output. A sample of 0 goes to DATA with bit index 0.
  - DATA: shift in 8 bits LSB first. After bit 7, go to PARITY if parity_en_i=1, else STOP1.
  - PARITY: expected bit = XOR of the data bits, XOR parity_odd_i. Latch the mismatch.
  - STOP1: a sample of 0 sets frame error. Go to STOP2 if stop2_i=1, else to DONE.
  - STOP2: a sample of 0 sets frame error; then go to DONE.
  - DONE: a single-cycle state that transfers the frame to the holding register, then goes to IDLE.
  - On a frame error, IDLE requires a synced high level before a new falling edge can start a frame.
- Config sampling: parity_en_i, parity_odd_i and stop2_i are sampled at the START→DATA transition and held for the whole frame.
- rx_en_i deasserted mid-frame: next cycle, FSM goes to IDLE and the partial frame is discarded. The holding register is unaffected.
- Holding register and handshake:
  - In DONE, if rx_valid_o=0, or rx_ready_i=1 in the same cycle: load data and flags, rx_valid_o=1 next cycle.
  - Otherwise: overrun_o pulses 1 cycle, the new frame is dropped, and the old byte is retained.
  - Transfer occurs when rx_valid_o && rx_ready_i. rx_valid_o clears next cycle unless a DONE load happens in the same cycle; then valid stays 1 with the new byte.
  - rx_data_o and the flags are stable while rx_valid_o=1 and rx_ready_i=0.
- Latency: rx_valid_o rises 1 cycle after DONE. DONE is entered at tick 15 of the last stop bit.
- Reset mid-frame or mid-handshake: immediate return to reset values on the next clock edge; the pending byte is lost.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Defined:
  - If a frame has all data bits 0, the parity bit (if present) is 0, and STOP1 samples 0, then break_o pulses 1 cycle in DONE.
  - The frame is still delivered with frame_err_o=1.
  - No further frame starts until the line is high for 1 full bit time (16 ticks).
- Not defined: break_o is tied to 0 and there is no extra idle-high wait beyond the frame-error rule.

Test Plan:
- baud_div_i=14 (bit = 224 cycles, ≈116 kbaud), 8N1, send 0xA5, rx_ready_i=1 → rx_data_o=0xA5, rx_valid_o high 1 cycle, both error flags 0.
- Even parity, send 0x3C with parity bit 1 → rx_data_o=0x3C, parity_err_o=1. Repeat with parity_odd_i=1 → parity_err_o=0.
- stop2_i=1, send 0x55 with second stop bit driven 0 → frame_err_o=1, data 0x55. Next frame 0x0F, sent after a high gap, is received clean.
- rx_ready_i=0, send 0x11 then 0x22 → rx_data_o stays 0x11, overrun_o pulses once at the 0x22 DONE. Then assert ready: 0x11 accepted and rx_valid_o drops.
- Low glitch of 100 cycles on idle urxd → no rx_valid_o, FSM back in IDLE. Asserting rst26m mid-DATA → all outputs 0 the next cycle, and the following frame 0x81 is received correctly.
- With UART_RX_BREAK_DET_EN, hold urxd low for 12 bit times → break_o pulses once, rx_data_o=0x00 with frame_err_o=1. Without the macro, break_o stays 0.
